// File: rtl/complex_pkg.sv
// Shared constants and width helpers for the complex multiply / accumulate chain.
package complex_pkg;

    // Accumulator control state, derived from the sample counter.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_ACCUM = 1'b1
    } acc_state_e;

    // Ceiling log2, valid for v >= 1 (returns 0 for v <= 1).
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = 32'(i) + 32'd1;
            end
        end
        return r;
    endfunction

    // Width of a complex product component from operand width.
    function automatic int unsigned prod_width(input int unsigned w);
        return 2 * w + 1;
    endfunction

    // Full-precision width of a sum of up to max_len in_w-bit samples.
    function automatic int unsigned acc_width(input int unsigned in_w, input int unsigned max_len);
        return in_w + clog2(max_len);
    endfunction

endpackage

// File: rtl/accum_lane.sv
// One signed accumulator lane: load/add on samples, registered dump of the full sum.
module accum_lane
    import complex_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = 5,
    parameter int unsigned OUT_WIDTH = 13
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_i,
    input  logic                 add_i,
    input  logic                 dump_i,
    input  logic [IN_WIDTH-1:0]  sample_i,
    output logic [OUT_WIDTH-1:0] sum_o
);

    localparam int unsigned EXT_W = OUT_WIDTH - IN_WIDTH;

    logic [OUT_WIDTH-1:0] sample_ext;
    logic [OUT_WIDTH-1:0] acc_d;
    logic [OUT_WIDTH-1:0] acc_q;
    logic [OUT_WIDTH-1:0] sum_q;

    // First sample of a frame replaces the running sum instead of adding to it.
    always_comb begin
        sample_ext = {{EXT_W{sample_i[IN_WIDTH-1]}}, sample_i};
        acc_d      = load_i ? sample_ext : acc_q + sample_ext;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            sum_q <= '0;
        end else begin
            if (load_i || add_i) begin
                acc_q <= acc_d;
            end
            if (dump_i) begin
                sum_q <= acc_d;
            end
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/complex_accum_dump.sv
// Integrate-and-dump of a complex product stream: one full-precision sum per frame.
module complex_accum_dump
    import complex_pkg::*;
#(
    parameter  int unsigned IN_WIDTH  = 5,
    parameter  int unsigned MAX_LEN   = 256,
    localparam int unsigned CNT_W     = clog2(MAX_LEN + 1),
    localparam int unsigned OUT_WIDTH = acc_width(IN_WIDTH, MAX_LEN)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sync,
    input  logic [CNT_W-1:0]     acc_len,
    input  logic                 p_valid,
    input  logic [IN_WIDTH-1:0]  pr,
    input  logic [IN_WIDTH-1:0]  pi,
    output logic                 s_valid,
    output logic [OUT_WIDTH-1:0] sr,
    output logic [OUT_WIDTH-1:0] si,
    output logic                 s_abort
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] len_q;
    logic             s_valid_q;
    logic             s_abort_q;

    acc_state_e       state_c;
    logic [CNT_W-1:0] len_start_c;
    logic [CNT_W-1:0] len_eff_c;
    logic [CNT_W-1:0] cnt_inc_c;
    logic             start_c;
    logic             add_c;
    logic             done_c;

    // Frame control: a sync with a sample restarts the frame on that sample.
    always_comb begin
        state_c = (cnt_q == '0) ? ST_EMPTY : ST_ACCUM;

        if (acc_len == '0) begin
            len_start_c = CNT_W'(1);
        end else if (acc_len > CNT_W'(MAX_LEN)) begin
            len_start_c = CNT_W'(MAX_LEN);
        end else begin
            len_start_c = acc_len;
        end

        start_c   = p_valid && (sync || (state_c == ST_EMPTY));
        add_c     = p_valid && !sync && (state_c == ST_ACCUM);
        len_eff_c = start_c ? len_start_c : len_q;
        cnt_inc_c = start_c ? CNT_W'(1) : cnt_q + CNT_W'(1);
        done_c    = p_valid && (cnt_inc_c == len_eff_c);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            len_q     <= CNT_W'(1);
            s_valid_q <= 1'b0;
            s_abort_q <= 1'b0;
        end else begin
            s_valid_q <= done_c;
            s_abort_q <= sync && (state_c == ST_ACCUM);

            if (done_c) begin
                cnt_q <= '0;
            end else if (p_valid) begin
                cnt_q <= cnt_inc_c;
            end else if (sync) begin
                cnt_q <= '0;
            end

            if (start_c) begin
                len_q <= len_start_c;
            end
        end
    end

    accum_lane #(
        .IN_WIDTH (IN_WIDTH),
        .OUT_WIDTH(OUT_WIDTH)
    ) u_lane_re (
        .clk     (clk),
        .rst     (rst),
        .load_i  (start_c),
        .add_i   (add_c),
        .dump_i  (done_c),
        .sample_i(pr),
        .sum_o   (sr)
    );

    accum_lane #(
        .IN_WIDTH (IN_WIDTH),
        .OUT_WIDTH(OUT_WIDTH)
    ) u_lane_im (
        .clk     (clk),
        .rst     (rst),
        .load_i  (start_c),
        .add_i   (add_c),
        .dump_i  (done_c),
        .sample_i(pi),
        .sum_o   (si)
    );

    assign s_valid = s_valid_q;
    assign s_abort = s_abort_q;

endmodule

// File: tb/tb_complex_accum_dump.sv
// Scoreboard bench for complex_accum_dump against a frame-level reference model.
module tb_complex_accum_dump;
    import complex_pkg::*;

    localparam int unsigned IN_WIDTH  = 5;
    localparam int unsigned MAX_LEN   = 8;
    localparam int unsigned CNT_W     = clog2(MAX_LEN + 1);
    localparam int unsigned OUT_WIDTH = IN_WIDTH + clog2(MAX_LEN);

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 sync = 1'b0;
    logic [CNT_W-1:0]     acc_len = '0;
    logic                 p_valid = 1'b0;
    logic [IN_WIDTH-1:0]  pr = '0;
    logic [IN_WIDTH-1:0]  pi = '0;
    logic                 s_valid;
    logic [OUT_WIDTH-1:0] sr;
    logic [OUT_WIDTH-1:0] si;
    logic                 s_abort;

    complex_accum_dump #(
        .IN_WIDTH(IN_WIDTH),
        .MAX_LEN (MAX_LEN)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .sync   (sync),
        .acc_len(acc_len),
        .p_valid(p_valid),
        .pr     (pr),
        .pi     (pi),
        .s_valid(s_valid),
        .sr     (sr),
        .si     (si),
        .s_abort(s_abort)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned edge_n;
        bit          v;
        bit          a;
        int          sr;
        int          si;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned edge_cnt = 0;
    bit          rst_seen = 1'b0;
    int          n_checks = 0;
    int          n_pass   = 0;

    // Reference model state: the frame in progress and the last dumped sum.
    int m_cnt = 0;
    int m_len = 1;
    int m_sr  = 0;
    int m_si  = 0;
    int m_last_sr = 0;
    int m_last_si = 0;

    always @(posedge clk) begin
        edge_cnt <= edge_cnt + 1;
        rst_seen <= rst;
    end

    task automatic check(input string name, input bit ok, input string detail);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s at edge %0d: %s", name, edge_cnt, detail);
    endtask

    function automatic int clamp_len(input int len);
        if (len == 0) return 1;
        if (len > int'(MAX_LEN)) return int'(MAX_LEN);
        return len;
    endfunction

    // Predict the outputs that follow one cycle of inputs.
    task automatic model(input bit r, input bit s, input bit v, input int len, input int a, input int b);
        exp_t e;
        e.edge_n = edge_cnt + 1;
        e.v = 1'b0;
        e.a = 1'b0;
        if (r) begin
            m_cnt = 0;
            m_last_sr = 0;
            m_last_si = 0;
            return;
        end
        if (s) begin
            if (m_cnt > 0) e.a = 1'b1;
            m_cnt = 0;
        end
        if (v) begin
            if (m_cnt == 0) begin
                m_len = clamp_len(len);
                m_sr = 0;
                m_si = 0;
            end
            m_sr += a;
            m_si += b;
            m_cnt++;
            if (m_cnt == m_len) begin
                e.v = 1'b1;
                m_last_sr = m_sr;
                m_last_si = m_si;
                m_cnt = 0;
            end
        end
        e.sr = m_last_sr;
        e.si = m_last_si;
        if (e.v || e.a) exp_q.push_back(e);
    endtask

    task automatic step(input bit r, input bit s, input bit v, input int len, input int a, input int b);
        @(posedge clk);
        #1;
        rst     = r;
        sync    = s;
        p_valid = v;
        acc_len = CNT_W'(len);
        pr      = IN_WIDTH'(a);
        pi      = IN_WIDTH'(b);
        model(r, s, v, len, a, b);
    endtask

    task automatic smp(input int len, input int a, input int b);
        step(1'b0, 1'b0, 1'b1, len, a, b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0, 0, 0);
    endtask

    // Monitor: pops an expectation whenever the DUT pulses, checks holds otherwise.
    int held_sr = 0;
    int held_si = 0;
    always @(negedge clk) begin
        int act_sr;
        int act_si;
        exp_t e;
        act_sr = int'($signed(sr));
        act_si = int'($signed(si));
        if (rst_seen) begin
            check("reset_state", !s_valid && !s_abort && act_sr == 0 && act_si == 0,
                  $sformatf("v=%0b a=%0b sr=%0d si=%0d, required all zero", s_valid, s_abort, act_sr, act_si));
            held_sr = 0;
            held_si = 0;
        end else if (s_valid || s_abort) begin
            if (exp_q.size() == 0 || exp_q[0].edge_n != edge_cnt) begin
                check("unexpected_pulse", 1'b0,
                      $sformatf("v=%0b a=%0b sr=%0d si=%0d, required no pulse", s_valid, s_abort, act_sr, act_si));
            end else begin
                e = exp_q.pop_front();
                check("pulse", s_valid == e.v && s_abort == e.a && act_sr == e.sr && act_si == e.si,
                      $sformatf("v=%0b a=%0b sr=%0d si=%0d, required v=%0b a=%0b sr=%0d si=%0d",
                                s_valid, s_abort, act_sr, act_si, e.v, e.a, e.sr, e.si));
                held_sr = e.sr;
                held_si = e.si;
            end
        end else begin
            if (exp_q.size() != 0 && exp_q[0].edge_n <= edge_cnt) begin
                e = exp_q.pop_front();
                check("missing_pulse", 1'b0,
                      $sformatf("no pulse, required v=%0b a=%0b sr=%0d si=%0d", e.v, e.a, e.sr, e.si));
            end
            check("hold", act_sr == held_sr && act_si == held_si,
                  $sformatf("sr=%0d si=%0d, required sr=%0d si=%0d", act_sr, act_si, held_sr, held_si));
        end
    end

    initial begin
        step(1'b1, 1'b0, 1'b0, 0, 0, 0);
        step(1'b1, 1'b0, 1'b0, 0, 0, 0);
        idle(2);

        // Basic frame: sr=10, si=-4.
        for (int i = 1; i <= 4; i++) smp(4, i, -1);
        idle(3);

        // Extremes: sr=-128, si=120.
        for (int i = 0; i < 8; i++) smp(8, -16, 15);
        idle(3);

        // Back-to-back len 2, then with 3-cycle gaps.
        for (int i = 1; i <= 4; i++) smp(2, i, i);
        idle(2);
        for (int i = 1; i <= 4; i++) begin
            smp(2, i, -i);
            idle(3);
        end

        // Sync abort with a sample that starts the next frame: sr=8.
        for (int i = 0; i < 3; i++) smp(4, 1, 0);
        step(1'b0, 1'b1, 1'b1, 4, 5, 2);
        for (int i = 0; i < 3; i++) smp(4, 1, 0);
        idle(3);

        // Edge lengths.
        smp(0, 3, -3);
        smp(0, -2, 7);
        smp(1, 7, -8);
        smp(1, -8, 1);
        idle(2);
        for (int i = 0; i < 8; i++) smp(12, i, 1);
        idle(2);
        smp(4, 1, 1);
        for (int i = 0; i < 3; i++) smp(2, 2, 3);
        idle(2);

        // Reset mid-frame, then a clean frame of 2s.
        smp(4, 3, 3);
        smp(4, 3, 3);
        step(1'b1, 1'b0, 1'b0, 4, 0, 0);
        for (int i = 0; i < 4; i++) smp(4, 2, 2);
        idle(3);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            bit r;
            bit s;
            bit v;
            r = ($urandom_range(0, 199) == 0);
            s = ($urandom_range(0, 19) == 0);
            v = ($urandom_range(0, 9) < 6);
            step(r, s, v, int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 31)) - 16, int'($urandom_range(0, 31)) - 16);
        end
        idle(4);

        check("drained", exp_q.size() == 0,
              $sformatf("%0d expectations pending, required 0", exp_q.size()));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
